simon32_64_decrypt: RTL and testbench
=====================================

// Module: simon32_64_decrypt
// PURPOSE
//  Iterative Simon32/64 decryptor, the inverse of the unrolled simon32_64 encryption pipeline.
//  Accepts one {ciphertext, key} pair per transaction on a valid/ready handshake.
//  Forward-expands the key schedule to k28..k31, then runs 32 inverse rounds at one round per cycle.
//  Key schedule runs in reverse on the fly. Sits on the receive side of the link, opposite the encryptor.
// PARAMETERS
//  C_CONST    16'hFFFC       key-schedule constant c (same as encryptor)
//  Z_SEQ      28'h386A45F    z bits; bit i = z_i used to derive k(i+4)
//  KEY_REUSE  1              1: skip expansion when key equals last expanded key
// PORTS
//  clk         in   1   clock
//  reset       in   1   asynchronous, active-high reset
//  in_valid    in   1   ciphertext/key present
//  in_ready    out  1   block idle, will accept
//  ciphertext  in   32  {x[31:16], y[15:0]}, same packing as encryptor output
//  key         in   64  {k3,k2,k1,k0}, k0 = key[15:0], same packing as encryptor key input
//  out_valid   out  1   plaintext valid, held until out_ready
//  out_ready   in   1   sink accepts plaintext
//  plaintext   out  32  {x,y} recovered block
//  busy        out  1   state != IDLE
// BEHAVIOUR
//  Reset values:
//   - out_valid=0, plaintext=0, busy=0.
//   - in_ready=1 (state IDLE); inputs are ignored while reset is high.
//   - Key cache invalidated.
//  FSM: IDLE -> EXPAND -> DECRYPT -> DONE -> IDLE.
//  IDLE
//   - in_ready=1.
//   - On in_valid: register ciphertext into state {x,y} and key words into window W3..W0.
//   - Go to EXPAND, or to DECRYPT on a cache hit (KEY_REUSE=1, cache valid, key == cached key).
//  EXPAND (28 cycles, counter i = 0..27)
//   - Wnew = C_CONST ^ Z_SEQ[i] ^ W0 ^ t ^ ror1(t), where t = ror3(W3) ^ W1.
//   - Shift the window: W <= {Wnew, W3, W2, W1}.
//   - On exit: W = {k31,k30,k29,k28}. Copy W and key into the cache; set cache valid.
//  DECRYPT (32 cycles, round r = 31 down to 0; kr = W3)
//   - Round: {x,y} <= {y, x ^ (rol1(y) & rol8(y)) ^ rol2(y) ^ kr}.
//   - Inverse schedule, only when r >= 4:
//     - k(r-4) = kr ^ C_CONST ^ Z_SEQ[r-4] ^ t ^ ror1(t), where t = ror3(W2) ^ W0.
//     - Shift the window: W <= {W2, W1, W0, k(r-4)}.
//   - On a cache hit, W is loaded from the cache on entry.
//  DONE
//   - out_valid=1 and plaintext={x,y}; both stay stable until out_ready.
//   - On out_ready: out_valid falls on the next edge; go to IDLE.
//  Latency (accept edge to out_valid high): 60 cycles on a miss, 32 on a hit.
//  Throughput: one block per latency + 2 cycles max. No overlap; in_ready=0 outside IDLE.
//  Arithmetic: all 16-bit; rotates are mod 16; no carries.
//  Boundary rules:
//   - in_valid with out_ready already high in DONE: no accept that cycle; accept next cycle in IDLE.
//   - Reset mid-EXPAND/DECRYPT: abort immediately; no out_valid; cache invalidated.
//   - Change of key: the cache only refreshes after a complete EXPAND.
//   - in_valid/ciphertext/key are sampled only at the accept edge; later changes are ignored.
// TESTING
//  1. ct=32'hC69BE9BB, key=64'h1918111009080100 -> plaintext=32'h65656877, out_valid 60 cycles after accept.
//  2. Same key again, ct=32'hC69BE9BB -> 32'h65656877 after 32 cycles (cache hit).
//     Then a new key -> 60 cycles.
//  3. Hold out_ready=0 for 10 cycles in DONE -> out_valid and plaintext stable, in_ready=0.
//     Release -> IDLE next cycle.
//  4. Assert reset at DECRYPT round 15, release -> out_valid=0, plaintext=0, in_ready=1.
//     Re-run vector 1 -> 60-cycle latency (cache cleared).
//  5. Loopback with the simon32_64 encryptor: 200 random {pt,key}, then decrypt the ciphertext ->
//     plaintext equals the original pt in every case.
//  6. ct=0, key=0 -> output equals the pt for which the encryptor gives ct=0.
//     Check by loopback with keys 0 and 64'hFFFF_FFFF_FFFF_FFFF.

Source files
------------

// File: rtl/simon32_64_decrypt.sv
// Iterative Simon32/64 decryptor: forward-expands the key to k31..k28, then runs
// 32 inverse rounds while regenerating round keys backwards, one round per cycle.
module simon32_64_decrypt #(
    parameter logic [15:0] C_CONST   = 16'hFFFC,
    parameter logic [27:0] Z_SEQ     = 28'h386A45F,
    parameter bit          KEY_REUSE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] ciphertext,
    input  logic [63:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] plaintext,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DECRYPT, S_DONE} state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [15:0] r_x, r_y;
    logic [15:0] r_w3, r_w2, r_w1, r_w0;
    logic        r_out_valid;
    logic [31:0] r_plaintext;
    logic        r_cache_valid;
    logic [63:0] r_cache_key;
    logic [63:0] r_cache_w;

    logic        w_hit;
    logic [15:0] w_t_exp, w_k_exp;
    logic [15:0] w_t_dec, w_k_dec;
    logic [4:0]  w_zidx_dec;
    logic [15:0] w_f;
    logic [15:0] w_y_next;

    assign w_hit = KEY_REUSE && r_cache_valid && (key == r_cache_key);

    assign w_t_exp = {r_w3[2:0], r_w3[15:3]} ^ r_w1;
    assign w_k_exp = C_CONST ^ {15'd0, Z_SEQ[r_cnt]} ^ r_w0 ^ w_t_exp ^ {w_t_exp[0], w_t_exp[15:1]};

    assign w_zidx_dec = r_cnt - 5'd4;
    assign w_t_dec    = {r_w2[2:0], r_w2[15:3]} ^ r_w0;
    assign w_k_dec    = r_w3 ^ C_CONST ^ {15'd0, Z_SEQ[w_zidx_dec]} ^ w_t_dec ^ {w_t_dec[0], w_t_dec[15:1]};

    assign w_f      = ({r_y[14:0], r_y[15]} & {r_y[7:0], r_y[15:8]}) ^ {r_y[13:0], r_y[15:14]};
    assign w_y_next = r_x ^ w_f ^ r_w3;

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign plaintext = r_plaintext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_w3          <= '0;
            r_w2          <= '0;
            r_w1          <= '0;
            r_w0          <= '0;
            r_out_valid   <= 1'b0;
            r_plaintext   <= '0;
            r_cache_valid <= 1'b0;
            r_cache_key   <= '0;
            r_cache_w     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x <= ciphertext[31:16];
                        r_y <= ciphertext[15:0];
                        if (w_hit) begin
                            {r_w3, r_w2, r_w1, r_w0} <= r_cache_w;
                            r_cnt   <= 5'd31;
                            r_state <= S_DECRYPT;
                        end else begin
                            {r_w3, r_w2, r_w1, r_w0} <= key;
                            // Key is captured now but only marked valid once EXPAND completes,
                            // so the cache never pairs a key with a partial schedule.
                            r_cache_key   <= key;
                            r_cache_valid <= 1'b0;
                            r_cnt         <= '0;
                            r_state       <= S_EXPAND;
                        end
                    end
                end
                S_EXPAND: begin
                    {r_w3, r_w2, r_w1, r_w0} <= {w_k_exp, r_w3, r_w2, r_w1};
                    if (r_cnt == 5'd27) begin
                        r_cache_w     <= {w_k_exp, r_w3, r_w2, r_w1};
                        r_cache_valid <= 1'b1;
                        r_cnt         <= 5'd31;
                        r_state       <= S_DECRYPT;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_DECRYPT: begin
                    r_x <= r_y;
                    r_y <= w_y_next;
                    // Below round 4 the window keeps rotating so W3 still presents k3..k0.
                    if (r_cnt >= 5'd4) begin
                        {r_w3, r_w2, r_w1, r_w0} <= {r_w2, r_w1, r_w0, w_k_dec};
                    end else begin
                        {r_w3, r_w2, r_w1, r_w0} <= {r_w2, r_w1, r_w0, r_w3};
                    end
                    if (r_cnt == 5'd0) begin
                        r_out_valid <= 1'b1;
                        r_plaintext <= {r_y, w_y_next};
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simon32_64_decrypt.sv
// Directed bench for simon32_64_decrypt, with a reference Simon32/64 encryptor for loopback.
module tb_simon32_64_decrypt;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ciphertext;
    logic [63:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] plaintext;
    logic        busy;

    int n_vec;
    int n_miss;

    localparam logic [63:0] K1     = 64'h1918111009080100;
    localparam logic [31:0] CT1    = 32'hC69BE9BB;
    localparam logic [31:0] PT1    = 32'h65656877;
    localparam logic [30:0] Z_BITS = 31'b1111101000100101011000011100110;

    simon32_64_decrypt #(
        .C_CONST  (16'hFFFC),
        .Z_SEQ    (28'h386A45F),
        .KEY_REUSE(1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ciphertext(ciphertext),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .plaintext (plaintext),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Textbook Simon32/64 encryption
    function automatic logic [31:0] enc(input logic [31:0] pt, input logic [63:0] k);
        logic [15:0] ks [32];
        logic [30:0] z;
        logic [15:0] tmp, x, y;
        z = Z_BITS;
        for (int i = 0; i < 4; i++) ks[i] = k[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            tmp = {ks[i-1][2:0], ks[i-1][15:3]} ^ ks[i-3];
            tmp = tmp ^ {tmp[0], tmp[15:1]};
            ks[i] = ~ks[i-4] ^ tmp ^ {15'd0, z[30-(i-4)]} ^ 16'd3;
        end
        x = pt[31:16];
        y = pt[15:0];
        for (int r = 0; r < 32; r++) begin
            tmp = x;
            x = y ^ ({x[14:0], x[15]} & {x[7:0], x[15:8]}) ^ {x[13:0], x[15:14]} ^ ks[r];
            y = tmp;
        end
        return {x, y};
    endfunction

    task automatic run_txn(input logic [31:0] ct, input logic [63:0] k,
                           output logic [31:0] pt, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        ciphertext = ct;
        key = k;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ciphertext = $urandom;
        key = {$urandom, $urandom};
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        pt = plaintext;
    endtask

    task automatic release_out;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        in_valid = 1'b1;
        ciphertext = CT1;
        key = K1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || plaintext !== 32'h0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL reset_state: ov=%b pt=%h busy=%b ir=%b, want 0 0 0 1",
                     out_valid, plaintext, busy, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b0 || in_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL reset_release_idle: busy=%b ir=%b, want 0 1", busy, in_ready);
        end
    endtask

    task automatic test_vector1;
        logic [31:0] pt;
        int lat;
        run_txn(CT1, K1, pt, lat);
        n_vec++;
        if (pt !== PT1) begin
            n_miss++;
            $display("FAIL vec1_pt: got %h want %h", pt, PT1);
        end
        n_vec++;
        if (lat !== 60) begin
            n_miss++;
            $display("FAIL vec1_latency: got %0d want 60", lat);
        end
        release_out();
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL vec1_return_idle: ir=%b ov=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_cache_hit;
        logic [31:0] pt, pt2, ct2;
        logic [63:0] k2;
        int lat;
        run_txn(CT1, K1, pt, lat);
        n_vec++;
        if (pt !== PT1 || lat !== 32) begin
            n_miss++;
            $display("FAIL hit_same_key: pt=%h lat=%0d want %h 32", pt, lat, PT1);
        end
        release_out();
        k2  = 64'h0123456789ABCDEF;
        pt2 = 32'h12345678;
        ct2 = enc(pt2, k2);
        run_txn(ct2, k2, pt, lat);
        n_vec++;
        if (pt !== pt2 || lat !== 60) begin
            n_miss++;
            $display("FAIL new_key_miss: pt=%h lat=%0d want %h 60", pt, lat, pt2);
        end
        release_out();
        run_txn(CT1, K1, pt, lat);
        n_vec++;
        if (pt !== PT1 || lat !== 60) begin
            n_miss++;
            $display("FAIL old_key_evicted: pt=%h lat=%0d want %h 60", pt, lat, PT1);
        end
        release_out();
    endtask

    task automatic test_backpressure;
        logic [31:0] pt;
        int lat;
        run_txn(CT1, K1, pt, lat);
        n_vec++;
        if (pt !== PT1 || lat !== 32) begin
            n_miss++;
            $display("FAIL bp_first: pt=%h lat=%0d want %h 32", pt, lat, PT1);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (out_valid !== 1'b1 || plaintext !== PT1 || in_ready !== 1'b0) begin
                n_miss++;
                $display("FAIL bp_hold_%0d: ov=%b pt=%h ir=%b want 1 %h 0",
                         c, out_valid, plaintext, in_ready, PT1);
            end
        end
        release_out();
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_miss++;
            $display("FAIL bp_release: ov=%b ir=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_done_ready_high;
        logic [31:0] pt;
        int lat;
        run_txn(CT1, K1, pt, lat);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1;
        ciphertext = CT1;
        key = K1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL done_no_accept: ir=%b busy=%b ov=%b want 1 0 0", in_ready, busy, out_valid);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_vec++;
        if (busy !== 1'b1) begin
            n_miss++;
            $display("FAIL done_accept_next: busy=%b want 1", busy);
        end
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_vec++;
        if (plaintext !== PT1 || lat !== 32) begin
            n_miss++;
            $display("FAIL done_followup: pt=%h lat=%0d want %h 32", plaintext, lat, PT1);
        end
        release_out();
    endtask

    task automatic test_reset_mid;
        logic [31:0] pt;
        int lat;
        @(negedge clk);
        in_valid = 1'b1;
        ciphertext = CT1;
        key = K1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        n_vec++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL mid_decrypt_busy: busy=%b ov=%b want 1 0", busy, out_valid);
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || plaintext !== 32'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            n_miss++;
            $display("FAIL mid_reset_state: ov=%b pt=%h ir=%b busy=%b want 0 0 1 0",
                     out_valid, plaintext, in_ready, busy);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_txn(CT1, K1, pt, lat);
        n_vec++;
        if (pt !== PT1 || lat !== 60) begin
            n_miss++;
            $display("FAIL after_reset_rerun: pt=%h lat=%0d want %h 60", pt, lat, PT1);
        end
        release_out();
    endtask

    task automatic test_loopback;
        logic [31:0] pt, ct, got;
        logic [63:0] k;
        int lat;
        k = {$urandom, $urandom};
        for (int i = 0; i < 200; i++) begin
            pt = $urandom;
            if (i % 4 != 1) k = {$urandom, $urandom};
            ct = enc(pt, k);
            run_txn(ct, k, got, lat);
            n_vec++;
            if (got !== pt) begin
                n_miss++;
                $display("FAIL loopback_%0d: got %h want %h (key %h lat %0d)", i, got, pt, k, lat);
            end
            release_out();
        end
    endtask

    task automatic test_zero;
        logic [31:0] got;
        logic [63:0] k;
        int lat;
        for (int j = 0; j < 2; j++) begin
            k = (j == 0) ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFF;
            run_txn(32'h0, k, got, lat);
            n_vec++;
            if (enc(got, k) !== 32'h0) begin
                n_miss++;
                $display("FAIL zero_ct_key%0d: enc(%h)=%h want 00000000", j, got, enc(got, k));
            end
            release_out();
        end
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        ciphertext = '0;
        key = '0;
        test_reset();
        test_vector1();
        test_cache_hit();
        test_backpressure();
        test_done_ready_high();
        test_reset_mid();
        test_loopback();
        test_zero();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
